// File: rtl/i2c_bridge_pkg.sv
// Shared types and constants for the I2C target front end.
//   - i2c_state_e : byte-level target FSM states
//   - I2C_ADDR_W / I2C_BYTE_W : address and data widths
//   - bit_cnt_inc : saturating increment for the 4-bit bit counter
package i2c_bridge_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  // The bit counter stops at 9 (8 data bits plus the ACK clock) and never wraps.
  localparam logic [3:0] BIT_CNT_MAX = 4'd9;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdLoad,
    StRdData,
    StRdAck,
    StWaitStop
  } i2c_state_e;

  function automatic logic [3:0] bit_cnt_inc(input logic [3:0] cnt);
    return (cnt >= BIT_CNT_MAX) ? BIT_CNT_MAX : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Pad synchroniser and edge detector for one I2C line (SCL or SDA).
//   clk, rst  : system clock, synchronous active-high reset
//   line_i    : raw pad input
//   level_o   : synchronised (optionally filtered) line level
//   rise_o    : one-cycle pulse on a rising edge of level_o
//   fall_o    : one-cycle pulse on a falling edge of level_o
// Build option I2C_GLITCH_FILTER_EN inserts a 3-sample majority filter after
// the synchroniser, rejecting single-cycle spikes at the cost of 2 cycles.
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   synced;
  logic                   filt;
  logic                   prev_q, prev_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
  assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] hist_q, hist_d;

  assign hist_d = {hist_q[1:0], synced};
  assign filt   = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

  always_ff @(posedge clk) begin
    if (rst) hist_q <= '1;
    else     hist_q <= hist_d;
  end
`else
  assign filt = synced;
`endif

  assign prev_d = filt;

  // Idle bus level is high; resetting to 1 avoids a spurious edge at start-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = filt;
  assign rise_o  = filt & ~prev_q;
  assign fall_o  = ~filt & prev_q;

endmodule

// File: rtl/i2c_target_frontend.sv
// Byte-level I2C target front end for the bridge core.
//   clk, rst           : system clock (>= 16x SCL), synchronous active-high reset
//   scl_i, sda_i       : pad inputs
//   scl_oe, sda_oe     : open-drain pull-low enables (stretch / ACK / read data)
//   rx_data, rx_valid  : received write byte and its one-cycle strobe
//   rx_first           : rx_valid qualifier, first byte after the address
//   tx_data, tx_valid  : next read byte from the core
//   tx_ready           : tx_data consumed this cycle
//   rw                 : latched R/W bit of the current transfer
//   start_o, stop_o    : START/repeated START and STOP pulses
//   busy               : address matched, until STOP
// Build option I2C_GLITCH_FILTER_EN enables the majority filter in i2c_line_sync.
module i2c_target_frontend
  import i2c_bridge_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h2A,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  scl_oe,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_first,
  input  logic [I2C_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  rw,
  output logic                  start_o,
  output logic                  stop_o,
  output logic                  busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  rx_first_q, rx_first_d;
  logic                  first_q, first_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  scl_oe_q, scl_oe_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  load;
  logic [I2C_BYTE_W-1:0] shift_in;

  assign shift_in = {shift_q[I2C_BYTE_W-2:0], sda_lvl};

  // Read byte hand-off: combinational so that tx_data is taken in the tx_ready cycle.
  assign load = (state_q == StRdLoad) & tx_valid & ~start_det & ~stop_det & ~rst;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_first_d = 1'b0;
    first_d    = first_q;
    rw_d       = rw_q;
    busy_d     = busy_q;
    sda_oe_d   = sda_oe_q;
    scl_oe_d   = scl_oe_q;
    start_d    = 1'b0;
    stop_d     = 1'b0;

    if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      first_d   = 1'b0;
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b0;
      stop_d    = 1'b1;
    end else if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      shift_d   = '0;
      first_d   = 1'b0;
      sda_oe_d  = 1'b0;
      scl_oe_d  = 1'b0;
      start_d   = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;

        StAddr: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_inc(bit_cnt_q);
            if (bit_cnt_q == 4'd7) begin
              if (shift_q[I2C_ADDR_W-1:0] == TARGET_ADDR) begin
                state_d = StAddrAck;
                rw_d    = sda_lvl;
                busy_d  = 1'b1;
              end else begin
                state_d = StWaitStop;
              end
            end
          end
        end

        // Counter at 8: fall ending bit 8, start driving ACK. At 9: closing fall.
        StAddrAck: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = bit_cnt_inc(bit_cnt_q);
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (rw_q) begin
                state_d  = StRdLoad;
                scl_oe_d = 1'b1;
              end else begin
                state_d = StWrData;
                first_d = 1'b1;
              end
            end
          end
        end

        StWrData: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_inc(bit_cnt_q);
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              rx_first_d = first_q;
              first_d    = 1'b0;
              state_d    = StWrAck;
            end
          end
        end

        StWrAck: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = bit_cnt_inc(bit_cnt_q);
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = StWrData;
            end
          end
        end

        // SCL is low here, so presenting the MSB on load is safe.
        StRdLoad: begin
          if (load) begin
            shift_d   = tx_data;
            sda_oe_d  = ~tx_data[I2C_BYTE_W-1];
            scl_oe_d  = 1'b0;
            bit_cnt_d = '0;
            state_d   = StRdData;
          end else begin
            scl_oe_d = 1'b1;
          end
        end

        StRdData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd8;
              state_d   = StRdAck;
            end else begin
              shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              sda_oe_d  = ~shift_q[I2C_BYTE_W-2];
              bit_cnt_d = bit_cnt_inc(bit_cnt_q);
            end
          end
        end

        StRdAck: begin
          if (scl_rise) begin
            if (sda_lvl) state_d = StWaitStop;
            else         bit_cnt_d = bit_cnt_inc(bit_cnt_q);
          end else if (scl_fall && bit_cnt_q == BIT_CNT_MAX) begin
            state_d   = StRdLoad;
            scl_oe_d  = 1'b1;
            bit_cnt_d = '0;
          end
        end

        StWaitStop: begin
          sda_oe_d = 1'b0;
          scl_oe_d = 1'b0;
        end

        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_first_q <= 1'b0;
      first_q    <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      sda_oe_q   <= 1'b0;
      scl_oe_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_first_q <= rx_first_d;
      first_q    <= first_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      sda_oe_q   <= sda_oe_d;
      scl_oe_q   <= scl_oe_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  // Stretch is dropped in the very cycle the byte is taken or the bus is re-framed.
  assign scl_oe   = scl_oe_q & ~(load | start_det | stop_det);
  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_first = rx_first_q;
  assign tx_ready = load;
  assign rw       = rw_q;
  assign start_o  = start_q;
  assign stop_o   = stop_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target_frontend.sv
// Directed bench for i2c_target_frontend: a bit-banged I2C master drives the
// open-drain pads, a negedge monitor logs DUT pulses, and each test task
// compares against hand-computed values.
module tb_i2c_target_frontend;

  localparam int Q = 5;  // quarter SCL period in clk cycles

  logic       clk, rst;
  logic       scl_m, sda_m;
  logic       scl_pad, sda_pad;
  logic       scl_oe, sda_oe;
  logic [7:0] rx_data, tx_data;
  logic       rx_valid, rx_first, tx_valid, tx_ready, rw, start_o, stop_o, busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         rx_cnt = 0, start_cnt = 0, stop_cnt = 0, txr_cnt = 0, sda_drv_cnt = 0;
  logic [7:0] rx_log    [64];
  logic       first_log [64];

  assign scl_pad = scl_m & ~scl_oe;
  assign sda_pad = sda_m & ~sda_oe;

  i2c_target_frontend #(
    .TARGET_ADDR(7'h2A),
    .SYNC_STAGES(2)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_pad),
    .sda_i   (sda_pad),
    .scl_oe  (scl_oe),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_first(rx_first),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rw      (rw),
    .start_o (start_o),
    .stop_o  (stop_o),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid === 1'b1) begin
        if (rx_cnt < 64) begin
          rx_log[rx_cnt]    = rx_data;
          first_log[rx_cnt] = rx_first;
        end
        rx_cnt++;
      end
      if (start_o === 1'b1)  start_cnt++;
      if (stop_o === 1'b1)   stop_cnt++;
      if (tx_ready === 1'b1) txr_cnt++;
      if (sda_oe === 1'b1)   sda_drv_cnt++;
    end
  end

  // ---------------- master bit-bang primitives ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int k = 0;
    @(negedge clk);
    while (scl_pad !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (scl_pad !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL scl_release_timeout: scl=%b required 1 within 2000 cycles", scl_pad);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    wait_scl_high();
    cyc(2 * Q);
    sda_m = 1'b0;
    cyc(2 * Q);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    wait_scl_high();
    cyc(2 * Q);
    sda_m = 1'b1;
    cyc(2 * Q);
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    cyc(Q);
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    wait_scl_high();
    if (glitch) begin
      cyc(Q);
      scl_m = 1'b0;
      cyc(1);
      scl_m = 1'b1;
      cyc(Q);
    end else begin
      cyc(2 * Q);
    end
    scl_m = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1;
    cyc(2 * Q);
    scl_m = 1'b1;
    wait_scl_high();
    cyc(Q);
    b = sda_pad;
    cyc(Q);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cyc(4);
    n_checks++;
    if ({scl_oe, sda_oe, rx_valid, rx_first, tx_ready, rw, start_o, stop_o, busy} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 000000000",
               {scl_oe, sda_oe, rx_valid, rx_first, tx_ready, rw, start_o, stop_o, busy});
    end
    n_checks++;
    if (rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rx_data: got %h required 00", rx_data);
    end
    rst = 1'b0;
    cyc(10);
  endtask

  task automatic test_write();
    logic ack;
    int   s_rx = rx_cnt, s_st = start_cnt, s_sp = stop_cnt;
    i2c_start();
    write_byte(8'h54, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack: got %b required 0", ack); end
    n_checks++;
    if ({busy, rw} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_busy_rw: got busy,rw=%b required 10", {busy, rw});
    end
    write_byte(8'hA5, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data0_ack: got %b required 0", ack); end
    write_byte(8'h3C, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data1_ack: got %b required 0", ack); end
    i2c_stop();
    cyc(10);
    n_checks++;
    if (rx_cnt - s_rx !== 2) begin
      n_fail++;
      $display("FAIL wr_rx_count: got %0d required 2", rx_cnt - s_rx);
    end
    n_checks++;
    if ({rx_log[s_rx], first_log[s_rx]} !== {8'hA5, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_byte0: got %h first=%b required a5 first=1", rx_log[s_rx], first_log[s_rx]);
    end
    n_checks++;
    if ({rx_log[s_rx+1], first_log[s_rx+1]} !== {8'h3C, 1'b0}) begin
      n_fail++;
      $display("FAIL wr_byte1: got %h first=%b required 3c first=0",
               rx_log[s_rx+1], first_log[s_rx+1]);
    end
    n_checks++;
    if (start_cnt - s_st !== 1 || stop_cnt - s_sp !== 1) begin
      n_fail++;
      $display("FAIL wr_start_stop: got %0d/%0d required 1/1", start_cnt - s_st, stop_cnt - s_sp);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL wr_busy_end: got %b required 0", busy); end
    n_checks++;
    if (rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL wr_rx_hold: got %h required 3c", rx_data);
    end
  endtask

  task automatic test_addr_nack();
    logic ack;
    int   s_rx = rx_cnt, s_dr = sda_drv_cnt, s_sp = stop_cnt;
    i2c_start();
    write_byte(8'h56, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL nack_addr: got %b required 1", ack); end
    write_byte(8'h11, ack);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL nack_data: got %b required 1", ack); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL nack_busy: got %b required 0", busy); end
    n_checks++;
    if (stop_cnt - s_sp !== 0) begin
      n_fail++;
      $display("FAIL nack_early_stop: got %0d required 0", stop_cnt - s_sp);
    end
    i2c_stop();
    cyc(10);
    n_checks++;
    if (sda_drv_cnt - s_dr !== 0 || rx_cnt - s_rx !== 0) begin
      n_fail++;
      $display("FAIL nack_quiet: got sda_cycles=%0d rx=%0d required 0/0",
               sda_drv_cnt - s_dr, rx_cnt - s_rx);
    end
    n_checks++;
    if (stop_cnt - s_sp !== 1) begin
      n_fail++;
      $display("FAIL nack_stop: got %0d required 1", stop_cnt - s_sp);
    end
  endtask

  task automatic test_read();
    logic       ack;
    logic [7:0] d;
    int         s_tr = txr_cnt;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    i2c_start();
    write_byte(8'h55, ack);
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack: got %b required 0", ack); end
    read_byte(1'b1, d);
    n_checks++;
    if (d !== 8'hC3) begin n_fail++; $display("FAIL rd_byte: got %h required c3", d); end
    n_checks++;
    if ({busy, rw} !== 2'b11) begin
      n_fail++;
      $display("FAIL rd_busy_rw: got %b required 11", {busy, rw});
    end
    i2c_stop();
    tx_valid = 1'b0;
    cyc(10);
    n_checks++;
    if (txr_cnt - s_tr !== 1) begin
      n_fail++;
      $display("FAIL rd_tx_ready_count: got %0d required 1", txr_cnt - s_tr);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_stretch();
    logic       ack;
    logic [7:0] d;
    int         bad = 0, s_tr = txr_cnt;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    i2c_start();
    write_byte(8'h55, ack);
    cyc(10);
    for (int i = 0; i < 200; i++) begin
      if (scl_oe !== 1'b1) bad++;
      cyc(1);
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL st_hold: got %0d released cycles required 0", bad); end
    @(posedge clk);
    #1;
    tx_data  = 8'h96;
    tx_valid = 1'b1;
    #1;
    n_checks++;
    if ({tx_ready, scl_oe} !== 2'b10) begin
      n_fail++;
      $display("FAIL st_load: got tx_ready,scl_oe=%b required 10", {tx_ready, scl_oe});
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hFF;
    n_checks++;
    if (scl_oe !== 1'b0) begin n_fail++; $display("FAIL st_released: got %b required 0", scl_oe); end
    read_byte(1'b1, d);
    n_checks++;
    if (d !== 8'h96) begin n_fail++; $display("FAIL st_byte: got %h required 96", d); end
    i2c_stop();
    cyc(10);
    n_checks++;
    if (txr_cnt - s_tr !== 1) begin
      n_fail++;
      $display("FAIL st_tx_ready_count: got %0d required 1", txr_cnt - s_tr);
    end
  endtask

  task automatic test_reset_mid();
    logic ack;
    tx_valid = 1'b0;
    i2c_start();
    write_byte(8'h55, ack);
    cyc(10);
    n_checks++;
    if (scl_oe !== 1'b1) begin n_fail++; $display("FAIL rm_pre_stretch: got %b required 1", scl_oe); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({scl_oe, sda_oe, busy, rw} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rm_release: got scl,sda,busy,rw=%b required 0000", {scl_oe, sda_oe, busy, rw});
    end
    rst = 1'b0;
    i2c_stop();
    cyc(10);
  endtask

  task automatic test_rep_start();
    logic       ack;
    logic [7:0] d;
    int         s_rx = rx_cnt, s_st = start_cnt;
    i2c_start();
    write_byte(8'h54, ack);
    write_byte(8'hAA, ack);
    n_checks++;
    if (rw !== 1'b0) begin n_fail++; $display("FAIL rs_rw_write: got %b required 0", rw); end
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    i2c_start();
    write_byte(8'h55, ack);
    n_checks++;
    if ({ack, rw} !== 2'b01) begin
      n_fail++;
      $display("FAIL rs_rw_read: got ack,rw=%b required 01", {ack, rw});
    end
    read_byte(1'b1, d);
    n_checks++;
    if (d !== 8'h5A) begin n_fail++; $display("FAIL rs_read_byte: got %h required 5a", d); end
    i2c_stop();
    tx_valid = 1'b0;
    cyc(10);
    n_checks++;
    if (start_cnt - s_st !== 2) begin
      n_fail++;
      $display("FAIL rs_start_count: got %0d required 2", start_cnt - s_st);
    end
    i2c_start();
    write_byte(8'h54, ack);
    write_byte(8'h77, ack);
    i2c_stop();
    cyc(10);
    n_checks++;
    if (rx_cnt - s_rx !== 2) begin
      n_fail++;
      $display("FAIL rs_rx_count: got %0d required 2", rx_cnt - s_rx);
    end
    n_checks++;
    if ({rx_log[s_rx], first_log[s_rx], rx_log[s_rx+1], first_log[s_rx+1]} !==
        {8'hAA, 1'b1, 8'h77, 1'b1}) begin
      n_fail++;
      $display("FAIL rs_first: got %h/%b %h/%b required aa/1 77/1",
               rx_log[s_rx], first_log[s_rx], rx_log[s_rx+1], first_log[s_rx+1]);
    end
  endtask

`ifdef I2C_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic       ack;
    logic [7:0] d = 8'h69;
    int         s_rx = rx_cnt;
    i2c_start();
    write_byte(8'h54, ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == 4);
    read_bit(ack);
    i2c_stop();
    cyc(10);
    n_checks++;
    if (ack !== 1'b0 || rx_cnt - s_rx !== 1) begin
      n_fail++;
      $display("FAIL gl_count: got ack=%b rx=%0d required 0/1", ack, rx_cnt - s_rx);
    end
    n_checks++;
    if (rx_log[s_rx] !== 8'h69) begin
      n_fail++;
      $display("FAIL gl_byte: got %h required 69", rx_log[s_rx]);
    end
  endtask
`endif

  initial begin
    scl_m    = 1'b1;
    sda_m    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rst      = 1'b1;
    test_reset();
    test_write();
    test_addr_nack();
    test_read();
    test_stretch();
    test_reset_mid();
    test_rep_start();
`ifdef I2C_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_frontend.md
# i2c_target_frontend

Byte-level I2C target front end feeding the bridge core of `tt_um_vermiscore_i2c_spi_bridge`. It synchronises the SCL/SDA pads and detects START, repeated START and STOP. It matches the 7-bit target address, shifts write bytes out to the core, and shifts read bytes supplied by the core onto SDA. It drives ACK and stretches SCL when the core has no read byte ready.

## Interface
Parameters:
- `TARGET_ADDR`, 7'h2A: 7-bit address this target answers to.
- `SYNC_STAGES`, 2: flops in each pad synchroniser; minimum 2.

Ports:
- `clk`  in  1  system clock; frequency ≥ 16× SCL rate.
- `rst`  in  1  reset; synchronous, active-high.
- `scl_i`  in  1  SCL pad input.
- `sda_i`  in  1  SDA pad input.
- `scl_oe`  out  1  1 = pull SCL low (stretch); open-drain.
- `sda_oe`  out  1  1 = pull SDA low; open-drain.
- `rx_data`  out  8  received write byte; valid while `rx_valid` is high.
- `rx_valid`  out  1  one-cycle pulse per received data byte.
- `rx_first`  out  1  qualifies `rx_valid`: first data byte after an address phase.
- `tx_data`  in  8  next read byte from the core.
- `tx_valid`  in  1  `tx_data` is available.
- `tx_ready`  out  1  one-cycle pulse when `tx_data` is consumed.
- `rw`  out  1  latched R/W bit of the current transfer.
- `start_o`  out  1  pulse on START or repeated START.
- `stop_o`  out  1  pulse on STOP.
- `busy`  out  1  high from an address match until STOP.

## Operation
- SCL and SDA pass through `SYNC_STAGES` flops. Edges are detected on the synchronised values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both take priority over data handling in every state.
- Data bits are sampled on SCL rise. `sda_oe` and `scl_oe` change only on SCL fall, one cycle after the fall is detected.
- FSM states:
  - `IDLE`: waits for START.
  - START from any state → `ADDR`, with the bit counter and shift register cleared.
  - `ADDR`: shifts 8 bits in. Address = `TARGET_ADDR` → `ADDR_ACK`, `rw` latched, `busy`=1. Mismatch → `WAIT_STOP`; SDA is never driven.
  - `ADDR_ACK`: `sda_oe`=1 for the 9th clock. At the closing SCL fall: `rw`=0 → `WR_DATA`; `rw`=1 → `RD_LOAD`.
  - `WR_DATA`: shifts 8 bits in, MSB first. At the 8th SCL rise: `rx_valid` pulse, with `rx_first`=1 only for the first byte after the address. Then → `WR_ACK`. Every write byte is ACKed.
  - `WR_ACK`: `sda_oe`=1 for the 9th clock, then → `WR_DATA`.
  - `RD_LOAD`: if `tx_valid`=1, load the shift register from `tx_data`, pulse `tx_ready`, and → `RD_DATA`. Otherwise set `scl_oe`=1 and stay until `tx_valid`; `scl_oe` is released on the cycle of the load.
  - `RD_DATA`: drives the MSB first; `sda_oe` = ~bit. Shifts on each SCL fall. After the 8th fall, SDA is released → `RD_ACK`.
  - `RD_ACK`: samples master ACK at SCL rise. ACK (0) → `RD_LOAD` at the next fall. NACK (1) → `WAIT_STOP`.
  - `WAIT_STOP`: SDA released; waits for STOP or START.
- STOP from any state → `IDLE`: `busy`=0, `sda_oe`=`scl_oe`=0, `stop_o` pulse.

## Timing
- Reset values: state `IDLE`. Every output is 0, including `rw` and `rx_data`. Reset mid-transfer releases both lines in the next cycle.
- Pad-to-decision latency: `SYNC_STAGES`+1 cycles, plus 2 with `I2C_GLITCH_FILTER_EN`.
- `rx_valid` is asserted `SYNC_STAGES`+1 cycles after the 8th raw SCL rise. `rx_data` holds until the next `rx_valid`.
- `tx_data` is sampled only in the cycle where `tx_ready`=1.
- If STOP or START arrives during `RD_LOAD` while stretching, `scl_oe` is released immediately and no `tx_ready` pulse is issued.
- The bit counter is 4-bit and saturates at 9; it never wraps.

## Configuration
- `I2C_GLITCH_FILTER_EN`: adds a 3-sample majority filter after each synchroniser, so a single-cycle spike is rejected.
- Without the macro, synchronised values are used directly.

## Structure
- Package `i2c_bridge_pkg`: FSM state enum, `I2C_ADDR_W`=7, `I2C_BYTE_W`=8.
- Sub-module `i2c_line_sync` holds the synchroniser, the optional filter and rise/fall detect. It is instantiated for SCL and for SDA.

## Test plan
- Write 0x54 (addr 0x2A, W), then 0xA5, 0x3C, then STOP → ACK on both bytes. `rx_valid` pulses twice with data 0xA5 (`rx_first`=1), then 0x3C (`rx_first`=0). `stop_o` pulses and `busy` returns to 0.
- Address 0x2B, W → NACK (SDA never driven). No `rx_valid`. FSM stays in `WAIT_STOP` until STOP.
- Read 0x55 with `tx_valid` held high and `tx_data`=0xC3, master NACK → SDA bits 1100_0011. One `tx_ready` pulse. STOP returns the block to `IDLE`.
- Read with `tx_valid` low for 200 cycles → `scl_oe`=1 throughout. After `tx_valid` rises: `tx_ready` pulse, `scl_oe` released the same cycle, byte shifted correctly.
- Write 0xAA, then repeated START and read of 0x55 → `start_o` pulses twice and `rw` goes 0→1. `rx_first` is asserted again for the next write transfer.
- With `I2C_GLITCH_FILTER_EN`, a 1-cycle SCL low glitch mid-byte → no extra bit shifted and the byte is received intact.
